// File: rtl/rv_pkg.sv
// Shared constants for the RV control sequencer: opcodes, FSM encoding and
// instruction field positions.
package rv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int IMM_LSB = 20;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, TRAP
  } state_t;

endpackage

// File: rtl/rv_decode.sv
// Combinational opcode classifier and register/immediate field extraction.
module rv_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_rtype,
  output logic        is_itype,
  output logic        is_illegal,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] imm
);

  logic [6:0] opc;
  logic       unused_funct3;

  assign opc        = instr[OPC_LSB +: 7];
  assign is_rtype   = (opc == R_TYPE);
  assign is_itype   = (opc == I_TYPE);
  assign is_illegal = !(is_rtype || is_itype);
  assign rs1        = instr[RS1_LSB +: 5];
  assign rs2        = instr[RS2_LSB +: 5];
  assign rd         = instr[RD_LSB  +: 5];
  assign imm        = instr[IMM_LSB +: 12];

  // funct3/funct7 select the ALU op, which is the datapath's concern
  assign unused_funct3 = ^instr[14:12];

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the single-issue RV datapath.
// Define RV_ILLEGAL_TRAP_EN to trap on non-R/I opcodes; otherwise they retire as NOPs.
module rv_seq_ctrl
  import rv_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr_in,
  output logic [31:0]      instr_q,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             alu_imm_sel,
  output logic [11:0]      alu_imm,
  output logic             rf_wen,
  output logic             pc_en,
  output logic             busy,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal
);

  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EW-1:0] EXEC_LOAD = EW'(EXEC_CYCLES - 1);

  state_t        state, nxt;
  logic [EW-1:0] ex_cnt;
  logic          is_ri;

  logic          d_rtype, d_itype, d_illegal;
  logic [4:0]    d_rs1, d_rs2, d_rd;
  logic [11:0]   d_imm;

  rv_decode u_dec (
    .instr      (instr_q),
    .is_rtype   (d_rtype),
    .is_itype   (d_itype),
    .is_illegal (d_illegal),
    .rs1        (d_rs1),
    .rs2        (d_rs2),
    .rd         (d_rd),
    .imm        (d_imm)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    imem_req = 1'b0;
    pc_en    = 1'b0;
    rf_wen   = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:   if (run_en) nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) nxt = DECODE;
      end
      DECODE: begin
        if (!d_illegal) nxt = EXEC;
        else begin
`ifdef RV_ILLEGAL_TRAP_EN
          nxt = TRAP;
`else
          nxt = WB;
`endif
        end
      end
      EXEC:   if (ex_cnt == '0) nxt = WB;
      WB: begin
        pc_en  = 1'b1;
        rf_wen = is_ri && (rd_addr != 5'd0);
        nxt    = run_en ? FETCH : IDLE;
      end
      TRAP:   nxt = TRAP;
      default: nxt = IDLE;
    endcase
  end

  // Decoded fields are captured once in DECODE so they hold through EXEC and WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q     <= '0;
      rs1_addr    <= '0;
      rs2_addr    <= '0;
      rd_addr     <= '0;
      alu_imm     <= '0;
      alu_imm_sel <= 1'b0;
      is_ri       <= 1'b0;
      ex_cnt      <= '0;
      retire_cnt  <= '0;
    end else begin
      if (state == FETCH && imem_ack) instr_q <= instr_in;
      if (state == DECODE) begin
        rs1_addr    <= d_rs1;
        rs2_addr    <= d_rs2;
        rd_addr     <= d_rd;
        alu_imm     <= d_imm;
        alu_imm_sel <= d_itype;
        is_ri       <= d_rtype || d_itype;
        ex_cnt      <= EXEC_LOAD;
      end else if (state == EXEC && ex_cnt != '0) begin
        ex_cnt <= ex_cnt - EW'(1);
      end
      if (state == WB) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

`ifdef RV_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            illegal <= 1'b0;
    else if (state == DECODE && d_illegal) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Directed bench for rv_seq_ctrl: retirements are predicted into a queue at fetch
// time and checked when pc_en fires.
module tb_rv_seq_ctrl;

  localparam int EXEC  = 1;
  localparam int CNT_W = 16;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic             clk = 1'b0;
  logic             rst, run_en, imem_ack;
  logic [31:0]      instr_in, instr_q;
  logic             imem_req, alu_imm_sel, rf_wen, pc_en, busy, illegal;
  logic [4:0]       rs1_addr, rs2_addr, rd_addr;
  logic [11:0]      alu_imm;
  logic [CNT_W-1:0] retire_cnt;

  typedef struct {
    logic [31:0]      instr;
    logic             rfw;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  exp_t             push_e;
  logic [CNT_W-1:0] exp_cnt;
  int               tests = 0;
  int               fails = 0;

  always #5 clk = ~clk;

  rv_seq_ctrl #(.EXEC_CYCLES(EXEC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_in(instr_in), .instr_q(instr_q), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .alu_imm_sel(alu_imm_sel), .alu_imm(alu_imm), .rf_wen(rf_wen),
    .pc_en(pc_en), .busy(busy), .retire_cnt(retire_cnt), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pc_en must match the oldest predicted retirement
  always @(negedge clk) begin
    if (rst) begin
      chk("rf_wen_without_pc_en", {31'd0, rf_wen & ~pc_en}, 32'd0);
      if (pc_en) begin
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("wb_instr_q", instr_q, mon_e.instr);
          chk("wb_rs1", {27'd0, rs1_addr}, {27'd0, mon_e.instr[19:15]});
          chk("wb_rs2", {27'd0, rs2_addr}, {27'd0, mon_e.instr[24:20]});
          chk("wb_rd", {27'd0, rd_addr}, {27'd0, mon_e.instr[11:7]});
          chk("wb_imm", {20'd0, alu_imm}, {20'd0, mon_e.instr[31:20]});
          chk("wb_imm_sel", {31'd0, alu_imm_sel}, {31'd0, mon_e.instr[6:0] == OP_I});
          chk("wb_rf_wen", {31'd0, rf_wen}, {31'd0, mon_e.rfw});
          chk("wb_retire_cnt_pre", {16'd0, retire_cnt}, {16'd0, mon_e.cnt});
        end
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  // Fetch one instruction with dly cycles of ack delay; returns one cycle after WB
  task automatic run_instr(input logic [31:0] ins, input int dly, input bit spur, input bit drop_run);
    int  n;
    int  wb;
    bit  ri;
    ri = (ins[6:0] == OP_R) || (ins[6:0] == OP_I);
    wait_req();
    n = 0;
    repeat (dly) begin
      if (imem_req) n++;
      chk("pc_en_in_fetch", {31'd0, pc_en}, 32'd0);
      @(negedge clk);
    end
    if (imem_req) n++;
    chk("req_cycles", n, dly + 1);
    imem_ack = 1'b1;
    instr_in = ins;
    push_e.instr = ins;
    push_e.rfw   = ri && (ins[11:7] != 5'd0);
    push_e.cnt   = exp_cnt;
    sb.push_back(push_e);
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    instr_in = 32'h0;
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    wb = ri ? 2 + EXEC : 2;
    for (int k = 1; k < wb; k++) begin
      chk("pc_en_early", {31'd0, pc_en}, 32'd0);
      if (k == 2 && spur) begin
        imem_ack = 1'b1;
        instr_in = 32'hDEADBEEF;
      end
      if (k == 2 && drop_run) run_en = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      instr_in = 32'h0;
    end
    chk("pc_en_wb", {31'd0, pc_en}, 32'd1);
    @(negedge clk);
    chk("pc_en_after_wb", {31'd0, pc_en}, 32'd0);
    chk("retire_cnt", {16'd0, retire_cnt}, {16'd0, exp_cnt});
    if (spur) chk("instr_q_kept", instr_q, ins);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; run_en = 1'b0; imem_ack = 1'b0; instr_in = 32'h0; exp_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b1;
    run_en = 1'b1;

    run_instr(32'h002081B3, 0, 1'b0, 1'b0);   // add x3,x1,x2
    run_instr(32'hFFF00293, 0, 1'b0, 1'b0);   // addi x5,x0,-1
    run_instr(32'h002081B3, 3, 1'b1, 1'b0);   // delayed ack, spurious ack in EXEC

    // Reset in EXEC discards the instruction
    wait_req();
    imem_ack = 1'b1; instr_in = 32'h002081B3;
    @(negedge clk); imem_ack = 1'b0; instr_in = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("mid_rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("mid_rst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("mid_rst_instr_q", instr_q, 32'd0);
    chk("mid_rst_rd", {27'd0, rd_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;

    run_instr(32'h00208033, 0, 1'b0, 1'b1);   // add x0: no rf_wen; run_en dropped in EXEC
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("stop_idle", {31'd0, busy}, 32'd0);
    run_en = 1'b1;

`ifdef RV_ILLEGAL_TRAP_EN
    wait_req();
    imem_ack = 1'b1; instr_in = 32'h0;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    repeat (5) begin
      chk("trap_busy", {31'd0, busy}, 32'd1);
      chk("trap_pc_en", {31'd0, pc_en}, 32'd0);
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end
    chk("trap_cnt", {16'd0, retire_cnt}, {16'd0, exp_cnt});
    chk("trap_sticky", {31'd0, illegal}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("trap_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
`else
    run_instr(32'h00000000, 0, 1'b0, 1'b0);   // NOP retire
    chk("nop_illegal", {31'd0, illegal}, 32'd0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
